// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and timing constants for the sequential multiplier
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    MUL    = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } mult_state_e;

  localparam int MUL_ITERS = 32;

  // Edges from the start-sampling edge to the cycle where done is high
  localparam int LAT_U = 33;
  localparam int LAT_S = 37;

endpackage

// File: rtl/adder_32bits.sv
// rtl/adder_32bits.sv - 32-bit ripple adder with carry in and carry out
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, ci};

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - multi-cycle MULT/MULTU unit built around one shared 32-bit adder
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mult_state_e state_q;
  logic [31:0] mcand_q;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic [5:0]  cnt_q;
  logic        neg_res_q;
  logic        sgn_q;
  logic        cfix_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_s;
  logic        add_co;

  logic [31:0] p_hi_d;
  logic [31:0] p_lo_d;
  logic        sgn_d;

  assign sgn_d = is_signed & SIGNED_EN;

  // Steer the single adder: two's-complement negation passes, shift-add accumulate, sign fix
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      NEG_A: begin
        add_a  = ~mcand_q;
        add_ci = 1'b1;
      end
      NEG_B: begin
        add_a  = ~p_lo_q;
        add_ci = 1'b1;
      end
      MUL: begin
        add_a = p_hi_q;
        add_b = p_lo_q[0] ? mcand_q : 32'd0;
      end
      FIX_LO: begin
        add_a  = ~p_lo_q;
        add_ci = 1'b1;
      end
      FIX_HI: begin
        add_a  = ~p_hi_q;
        add_ci = cfix_q;
      end
      default: begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
      end
    endcase
  end

  adder_32bits u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  // One radix-2 step: the partial sum with its carry shifts right into the product pair
  assign {p_hi_d, p_lo_d} = {add_co, add_s, p_lo_q[31:1]};

  // Sequencer and datapath registers; flush outranks everything except reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      sgn_q     <= 1'b0;
      cfix_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mcand_q   <= op_a;
              p_lo_q    <= op_b;
              p_hi_q    <= '0;
              cnt_q     <= '0;
              cfix_q    <= 1'b0;
              sgn_q     <= sgn_d;
              neg_res_q <= sgn_d & (op_a[31] ^ op_b[31]);
              busy_q    <= 1'b1;
              state_q   <= sgn_d ? NEG_A : MUL;
            end
          end
          NEG_A: begin
            if (mcand_q[31]) mcand_q <= add_s;
            state_q <= NEG_B;
          end
          NEG_B: begin
            if (p_lo_q[31]) p_lo_q <= add_s;
            state_q <= MUL;
          end
          MUL: begin
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            cnt_q  <= cnt_q + 6'd1;
            if (cnt_q == 6'(MUL_ITERS - 1)) begin
              if (sgn_q) begin
                state_q <= FIX_LO;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
                hi_q    <= p_hi_d;
                lo_q    <= p_lo_d;
              end
            end
          end
          FIX_LO: begin
            if (neg_res_q) begin
              p_lo_q <= add_s;
              cfix_q <= add_co;
            end else begin
              cfix_q <= 1'b0;
            end
            state_q <= FIX_HI;
          end
          FIX_HI: begin
            hi_q    <= neg_res_q ? add_s : p_hi_q;
            lo_q    <= p_lo_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_seq_ctrl #(.SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and follow it to done, checking latency, result and return to idle
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int edges;
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s_busy_after_start: got %b expected 1", name, busy);
    end
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    n_cmp++;
    if (edges !== exp_lat) begin
      n_bad++; $display("FAIL %s_latency: got %0d expected %0d", name, edges, exp_lat);
    end
    n_cmp++;
    if (hi !== exp_hi) begin
      n_bad++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi);
    end
    n_cmp++;
    if (lo !== exp_lo) begin
      n_bad++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle_after: got busy=%b done=%b expected 0/0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op("u_3x5", 32'd3, 32'd5, 1'b0, 33, 32'h0, 32'hF);
    run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_signed();
    run_op("s_m7x3", 32'hFFFF_FFF9, 32'h3, 1'b1, 37, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 37, 32'h4000_0000, 32'h0);
    run_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 37, 32'h0, 32'h1);
    run_op("s_0xm5", 32'h0, 32'hFFFF_FFFB, 1'b1, 37, 32'h0, 32'h0);
    run_op("s_3xm1", 32'h3, 32'hFFFF_FFFF, 1'b1, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
  endtask

  task automatic test_flush();
    int seen_done;
    run_op("f_pre", 32'd3, 32'd5, 1'b0, 33, 32'h0, 32'hF);
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++; $display("FAIL flush_no_done: got %0d expected 0", seen_done);
    end
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'hF) begin
      n_bad++; $display("FAIL flush_hold: got hi=%h lo=%h expected 00000000/0000000f", hi, lo);
    end
    run_op("f_post", 32'd10, 32'd20, 1'b0, 33, 32'h0, 32'd200);
  endtask

  task automatic test_start_flush_idle();
    @(negedge clk);
    start = 1'b1; flush = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL start_flush_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_busy_start();
    int n_done;
    n_done = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op_a = 32'd100; op_b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done);
    end
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'd42) begin
      n_bad++; $display("FAIL busy_start_result: got hi=%h lo=%h expected 00000000/0000002a", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; op_a = 32'hFFFF_FFF9; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("r_post", 32'd4, 32'd4, 1'b0, 33, 32'h0, 32'd16);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_start_flush_idle();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle MULT/MULTU unit for the EX stage of the pipeline.
- Produces a 64-bit HI/LO product by sequencing a single shared adder_32bits instance through a radix-2 shift-add algorithm.
- Adds operand negation and result sign-fix passes for signed multiplies.
- Fixed latency, so hazard logic can stall on busy and capture on done.

Parameters:
- SIGNED_EN, 1: 1 = is_signed honoured; 0 = is_signed ignored, all operations treated as unsigned.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = MULT, 0 = MULTU; sampled with start
- op_a  in  32  multiplicand; sampled with start
- op_b  in  32  multiplier; sampled with start
- flush  in  1  synchronous abort (pipeline flush)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; hi/lo valid in that cycle
- hi  out  32  upper product word, registered
- lo  out  32  lower product word, registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, hi=0, lo=0, all internal registers 0.
- Internal registers:
  - mcand[31:0]; P_hi[31:0]; P_lo[31:0].
  - cnt[5:0] counts MUL iterations 0..31.
  - neg_res (result sign); sgn (latched is_signed & SIGNED_EN); cfix (carry between sign-fix passes).
- Adder use: exactly one adder_32bits; a, b and ci are muxed by state.
- States and transitions:
  - IDLE
    - start=1 & flush=0: latch op_a→mcand, op_b→P_lo, P_hi=0, cnt=0.
    - Then go to NEG_A if sgn, else MUL.
    - neg_res = sgn & (op_a[31]^op_b[31]).
  - NEG_A (1 cycle): if mcand[31], mcand ← ~mcand + 0, ci=1; else unchanged. → NEG_B.
  - NEG_B (1 cycle): same negation on P_lo using P_lo[31]. → MUL.
  - MUL (32 cycles), per cycle:
    - If P_lo[0]=1: {co,s} = P_hi + mcand (ci=0); else {co,s} = {0,P_hi}.
    - {P_hi,P_lo} ← {co,s,P_lo} >> 1.
    - cnt++.
    - At cnt=31: → FIX_LO if sgn, else DONE.
  - FIX_LO: if neg_res, lo-word ← ~P_lo + 0 with ci=1, cfix ← co; else cfix=0 and the word passes unchanged. → FIX_HI.
  - FIX_HI: if neg_res, hi-word ← ~P_hi + 0 with ci=cfix; else unchanged. → DONE.
  - DONE (1 cycle): done=1, busy=1. → IDLE.
- Output update:
  - hi/lo are written on the edge that enters DONE.
  - They hold until the next entry to DONE.
- Latency, counted from the edge that samples start:
  - Unsigned: done high in the cycle after 33 edges.
  - Signed: done high in the cycle after 37 edges.
  - Signed latency is fixed regardless of operand signs.
- Boundaries:
  - start while busy: ignored, no queueing.
  - start and flush together in IDLE: flush wins; request dropped.
  - flush in any non-IDLE state: IDLE on the next edge, no done pulse, hi/lo unchanged. This includes DONE, where done is still 1 in that cycle.
  - op_a or op_b = 0x80000000 signed: negation yields 0x80000000, a correct magnitude of 2^31.
  - Zero product with neg_res=1: sign-fix yields 0 (carry ripples through).
  - Reset mid-operation: immediate return to reset values.

Decomposition:
- Shared package mult_pkg:
  - State encoding constants: IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE.
  - MUL_ITERS = 32.
  - Latency constants LAT_U = 33 and LAT_S = 37, for the hazard unit.
- Sub-module: one instance of the existing adder_32bits (a, b, ci → s, co).
- No other sub-modules; FSM and datapath muxes live in mult_seq_ctrl.

Test Plan:
- Unsigned 3 × 5, start at cycle 0 → done in cycle 33, hi=0x00000000, lo=0x0000000F, busy low in cycle 34.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed −7 × 3 (0xFFFFFFF9, 0x00000003) → done in cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed operand cases:
  - 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
  - −1 × −1 → hi=0, lo=1.
  - 0 × −5 → hi=0, lo=0.
- Flush at cycle 10 of a MUL with prior result hi=0, lo=15 held → IDLE at cycle 11, no done, hi/lo still 0/15. A start at cycle 12 completes normally.
- Abort and ignore cases:
  - rst_n low at cycle 20 mid-op → busy, done, hi and lo all 0 asynchronously.
  - start pulsed while busy → ignored: exactly one done, result of the first operands.
